// File: rtl/gf_inv_4_pkg.sv
// Shared constants for the GF(2^4) nibble inverter used in the AES S-box datapath.
// The reference table feeds checks and assertions only; the datapath itself has no ROM.
package gf_inv_4_pkg;

  localparam int unsigned GF4_W = 4;

  typedef logic [GF4_W-1:0] nibble_t;

  // Inverse in the composite-field basis, indexed by the input nibble
  localparam nibble_t GF4_INV_TABLE [16] = '{
    4'h0, 4'h1, 4'h3, 4'h2, 4'hF, 4'hC, 4'h9, 4'hB,
    4'hA, 4'h6, 4'h8, 4'h7, 4'h5, 4'hE, 4'hD, 4'h4
  };

endpackage

// File: rtl/gf_inv_4_if.sv
// Valid/data bus of the registered GF(2^4) inverter; master feeds nibbles, slave returns inverses.
interface gf_inv_4_if
  import gf_inv_4_pkg::*;
();

  logic    valid_in;
  nibble_t data_in;
  logic    valid_out;
  nibble_t data_out;

  modport master (
    output valid_in,
    output data_in,
    input  valid_out,
    input  data_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output valid_out,
    output data_out
  );

endinterface

// File: rtl/gf_inv_4_comb.sv
// Combinational GF(2^4) inverse as an AND/XOR network; 0 maps to 0.
// Also instantiated directly by the unpipelined S-box variants.
module gf_inv_4_comb
  import gf_inv_4_pkg::*;
(
  input  nibble_t data_in,
  output nibble_t q
);

  logic a3, a2, a1, a0;

  assign {a3, a2, a1, a0} = data_in;

  assign q[3] = a3 ^ (a3 & a2 & a1) ^ (a3 & a0) ^ a2;

  assign q[2] = (a3 & a2 & a1) ^ (a3 & a2 & a0) ^ (a3 & a0) ^ a2 ^ (a2 & a1);

  assign q[1] = a3 ^ (a3 & a2 & a1) ^ (a3 & a1 & a0) ^ a2 ^ (a2 & a0) ^ a1;

  assign q[0] = (a3 & a2 & a1) ^ (a3 & a2 & a0) ^ (a3 & a1) ^ (a3 & a1 & a0)
              ^ (a3 & a0) ^ a2 ^ (a2 & a1) ^ (a2 & a1 & a0) ^ a1 ^ a0;

endmodule

// File: rtl/gf_inv_4.sv
// One-stage registered GF(2^4) inverter with a valid flag, retimable within the S-box pipeline.
// data_out is clock-enabled by valid_in, so idle cycles never load stale or unknown input.
module gf_inv_4
  import gf_inv_4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  gf_inv_4_if.slave  bus
);

  nibble_t inv_q;
  logic    valid_q;
  nibble_t data_q;

  gf_inv_4_comb u_comb (
    .data_in (bus.data_in),
    .q       (inv_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        data_q <= inv_q;
      end
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;

  // An accepted nibble must come out as its table inverse unless reset intervenes
  a_inv_matches_table: assert property (
    @(posedge clk) (rst_n && bus.valid_in) |=>
      (!rst_n || bus.data_out == GF4_INV_TABLE[$past(bus.data_in)])
  );

endmodule

// File: tb/tb_gf_inv_4.sv
// Bench for gf_inv_4: directed phases plus randomized traffic against a cycle-level model.
module tb_gf_inv_4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gf_inv_4_if bus ();

  gf_inv_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inverse by definition: the nibble pairs that multiply to 1 in this basis, written out by hand
  logic [3:0] inv_ref [16] = '{
    4'h0, 4'h1, 4'h3, 4'h2, 4'hF, 4'hC, 4'h9, 4'hB,
    4'hA, 4'h6, 4'h8, 4'h7, 4'h5, 4'hE, 4'hD, 4'h4
  };

  int total = 0;
  int bad   = 0;
  logic armed = 1'b0;

  // Model: one-cycle delay of (valid, inverse) with reset and a held data value
  logic       exp_valid;
  logic [3:0] exp_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_data  <= 4'h0;
      armed     <= 1'b1;
    end else begin
      exp_valid <= bus.valid_in;
      if (bus.valid_in) exp_data <= inv_ref[bus.data_in];
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (bus.valid_out !== exp_valid || bus.data_out !== exp_data) begin
        bad++;
        $display("FAIL model_cmp t=%0t: got valid=%b data=%h, want valid=%b data=%h",
                 $time, bus.valid_out, bus.data_out, exp_valid, exp_data);
      end
    end
  end

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [3:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] dir_in  [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h8, 4'hA, 4'hF};
  logic [3:0] dir_out [8] = '{4'hF, 4'h2, 4'h3, 4'h1, 4'h0, 4'hA, 4'h8, 4'h4};
  logic [3:0] outs [16];

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 4'h0;

    // Reset held three cycles with a valid nibble presented
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'h7);
      chk("reset_hold", {bus.valid_out, bus.data_out}, 5'h00);
    end
    rst_n = 1'b1;
    cyc(1'b0, 4'h7);
    chk("reset_release", {bus.valid_out, bus.data_out}, 5'h00);

    // Directed values, back-to-back
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, dir_in[i]);
      chk($sformatf("directed_%h", dir_in[i]), {bus.valid_out, bus.data_out}, {1'b1, dir_out[i]});
    end

    // Exhaustive sweep, then feed every result back to check the involution
    for (int unsigned a = 0; a < 16; a++) begin
      cyc(1'b1, 4'(a));
      outs[a] = bus.data_out;
      chk($sformatf("exhaustive_%h", a), {bus.valid_out, bus.data_out}, {1'b1, inv_ref[a]});
    end
    for (int unsigned a = 0; a < 16; a++) begin
      cyc(1'b1, outs[a]);
      chk($sformatf("involution_%h", a), {1'b0, bus.data_out}, {1'b0, 4'(a)});
    end
    for (int unsigned i = 0; i < 16; i++) begin
      for (int unsigned j = i + 1; j < 16; j++) begin
        if (outs[i] == outs[j]) begin
          total++;
          bad++;
          $display("FAIL distinct: inputs %0d and %0d both give %h, want distinct", i, j, outs[i]);
        end
      end
    end

    // Hold: data_out keeps its value while valid_in is low and data_in wiggles
    cyc(1'b1, 4'h4);
    chk("hold_first", {bus.valid_out, bus.data_out}, 5'h1F);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'($urandom_range(0, 15)));
      chk("hold_idle", {bus.valid_out, bus.data_out}, 5'h0F);
    end

    // Reset mid-stream drops the nibble presented with it
    cyc(1'b1, 4'h3);
    chk("midrst_pre", {bus.valid_out, bus.data_out}, 5'h12);
    rst_n = 1'b0;
    cyc(1'b1, 4'h4);
    chk("midrst_cleared", {bus.valid_out, bus.data_out}, 5'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h4);
      chk("midrst_no_emit", {bus.valid_out, bus.data_out}, 5'h00);
    end

    // Randomized traffic with sparse resets; the compare process checks every cycle
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end
    rst_n = 1'b1;
    cyc(1'b0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
